// File: rtl/pi_request_queue.sv
`timescale 1ns/1ps
// Pi-side front end: synchronises Pi register strobes, decodes writes into a
// posted request FIFO for the bus engine and holds completion data for readback.
module pi_request_queue #(
  parameter int          DEPTH      = 4,
  parameter logic [15:0] FW_VERSION = 16'h1040
) (
  input  logic        sys_clk,
  input  logic        nRESET,
  input  logic        pi_wr,
  input  logic        pi_rd,
  input  logic [2:0]  pi_a,
  input  logic [15:0] pi_data_in,
  output logic [15:0] pi_data_out,
  output logic        pi_data_oe,
  input  logic [7:0]  status_in,
  output logic [14:0] ctrl,
  output logic        busy,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [23:0] req_address,
  output logic [1:0]  req_size,
  output logic        req_read,
  output logic [2:0]  req_fc,
  output logic [31:0] req_data_write,
  input  logic        rsp_valid,
  input  logic        rsp_read,
  input  logic [31:0] rsp_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(DEPTH + 2);

  typedef struct packed {
    logic [23:0] addr;
    logic [1:0]  size;
    logic        read;
    logic [2:0]  fc;
    logic [31:0] data;
  } entry_t;

  logic [1:0]    wr_sync_q, rd_sync_q;
  logic [31:0]   data_q;
  logic [23:0]   addr_q;
  logic [1:0]    size_q;
  logic          read_q;
  logic [2:0]    fc_q;
  logic [14:0]   ctrl_q;
  logic [31:0]   rdata_q;
  logic          overflow_q, full_q, busy_q;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OW-1:0] outst_q, outst_d;
  entry_t        fifo_q [DEPTH];
  entry_t        new_entry, head;

  logic wr_ev, rd_end_ev, push_req, push, drop, pop, empty;

  // Older sample in bit 1: 2'b10 is a falling strobe, 2'b01 a rising one.
  assign wr_ev     = (wr_sync_q == 2'b10);
  assign rd_end_ev = (rd_sync_q == 2'b01) && (pi_a == 3'd4);
  assign push_req  = wr_ev && (pi_a == 3'd3);
  assign push      = push_req && !full_q;
  assign drop      = push_req && full_q;
  assign empty     = (count_q == '0);
  assign pop       = !empty && req_ready;

  assign new_entry = '{addr: {pi_data_in[7:0], addr_q[15:0]}, size: pi_data_in[9:8],
                       read: pi_data_in[10], fc: pi_data_in[13:11], data: data_q};

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // A response with nothing outstanding is ignored rather than wrapping.
  always_comb begin
    outst_d = outst_q;
    if (push && !rsp_valid)                          outst_d = outst_q + OW'(1);
    else if (!push && rsp_valid && outst_q != '0)    outst_d = outst_q - OW'(1);
  end

  always_ff @(posedge sys_clk or negedge nRESET) begin
    if (!nRESET) begin
      wr_sync_q  <= 2'b11;
      rd_sync_q  <= 2'b11;
      data_q     <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      read_q     <= 1'b0;
      fc_q       <= '0;
      ctrl_q     <= '0;
      rdata_q    <= '0;
      overflow_q <= 1'b0;
      full_q     <= 1'b0;
      busy_q     <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      outst_q    <= '0;
    end else begin
      wr_sync_q <= {wr_sync_q[0], pi_wr};
      rd_sync_q <= {rd_sync_q[0], pi_rd};
      if (wr_ev) begin
        case (pi_a)
          3'd0: data_q[15:0]  <= pi_data_in;
          3'd1: data_q[31:16] <= pi_data_in;
          3'd2: addr_q[15:0]  <= pi_data_in;
          3'd3: begin
            addr_q[23:16] <= pi_data_in[7:0];
            size_q        <= pi_data_in[9:8];
            read_q        <= pi_data_in[10];
            fc_q          <= pi_data_in[13:11];
          end
          3'd4: ctrl_q <= pi_data_in[15] ? (ctrl_q | pi_data_in[14:0])
                                         : (ctrl_q & ~pi_data_in[14:0]);
          default: ;
        endcase
      end
      if (drop)           overflow_q <= 1'b1;
      else if (rd_end_ev) overflow_q <= 1'b0;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      outst_q <= outst_d;
      busy_q  <= (outst_d != '0);
      if (rsp_valid && rsp_read) rdata_q <= rsp_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) fifo_q[wr_ptr_q] <= new_entry;
  end

  assign head           = fifo_q[rd_ptr_q];
  assign req_valid      = !empty;
  assign req_address    = head.addr;
  assign req_size       = head.size;
  assign req_read       = head.read;
  assign req_fc         = head.fc;
  assign req_data_write = head.data;
  assign ctrl           = ctrl_q;
  assign busy           = busy_q;
  assign pi_data_oe     = ~pi_rd & pi_wr;

  always_comb begin
    pi_data_out = 16'h0000;
    case (pi_a)
      3'd0: pi_data_out = rdata_q[15:0];
      3'd1: pi_data_out = rdata_q[31:16];
      3'd2: pi_data_out = addr_q[15:0];
      3'd3: pi_data_out = {2'b00, fc_q, read_q, size_q, addr_q[23:16]};
      3'd4: pi_data_out = {5'b00000, overflow_q, full_q, busy_q, status_in};
      3'd7: pi_data_out = FW_VERSION;
      default: pi_data_out = 16'h0000;
    endcase
  end

endmodule

// File: doc/pi_request_queue.md
# pi_request_queue

Pi-side front end for the PiStorm16 bus engine, clocked on `sys_clk`. It synchronises the Pi GPIO register strobes and decodes register writes into a small posted request FIFO. It presents queued Amiga bus requests to the access state machine with a valid/ready handshake, and captures completion data for Pi readback. Because writes are queued, the Pi can post several bus writes back-to-back without polling busy between each one.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..8.
- `FW_VERSION`, 16'h1040: value returned at register 7 (major 1, minor 0, type PS16).
- `sys_clk`  in  1  system clock (PLL output); the only clock.
- `nRESET`  in  1  asynchronous, active-low reset.
- `pi_wr`  in  1  raw Pi WR strobe, asynchronous.
- `pi_rd`  in  1  raw Pi RD strobe, asynchronous.
- `pi_a`  in  3  raw Pi register address.
- `pi_data_in`  in  16  raw Pi data.
- `pi_data_out`  out  16  combinational register readback, muxed on raw `pi_a`.
- `pi_data_oe`  out  1  `~pi_rd & pi_wr`, combinational.
- `status_in`  in  8  {ipl[2:0], halt, reset, is_bm, 2'b0}, already synchronised.
- `ctrl`  out  15  Pi control register (bit 0 BR, bit 1 RESET, bit 2 HALT drive).
- `busy`  out  1  high while any request is queued or in flight; drives GPIO3.
- `req_valid`  out  1  head entry available.
- `req_ready`  in  1  engine accepts the head entry.
- `req_address`  out  24  head entry byte address.
- `req_size`  out  2  head entry size code.
- `req_read`  out  1  head entry is a read.
- `req_fc`  out  3  head entry function code.
- `req_data_write`  out  32  head entry write data.
- `rsp_valid`  in  1  one-cycle pulse: engine finished one request.
- `rsp_read`  in  1  qualifies `rsp_valid`: the finished request was a read.
- `rsp_data`  in  32  read data, valid with `rsp_valid & rsp_read`.

## Operation
**Synchronisers**
- Each strobe has its own two-flop synchroniser.
- A write event is sync pattern 2'b10 on `pi_wr`.
- A status-read-end event is 2'b01 on `pi_rd` while the raw `pi_a` equals 4.
- `pi_a` and `pi_data_in` are sampled in the cycle the write event is detected.

**Write decode**
- 0: staging data[15:0].
- 1: staging data[31:16].
- 2: staging address[15:0].
- 3: sets address[23:16], size, read and fc from `pi_data_in` bits [7:0], [9:8], [10] and [13:11], then pushes the entry.
- 4: control register. If bit 15 is set, `ctrl |= d[14:0]`; otherwise `ctrl &= ~d[14:0]`.
- 5–7: writes are ignored.
- Staging registers persist after a push, so a repeat push only needs a new address.

**Readback**
- 0 and 1: last read-data word, low and high halves.
- 2: staged address[15:0].
- 3: {2'b0, fc, read, size, address[23:16]}.
- 4: {5'b0, overflow, full, busy, status_in}.
- 7: `FW_VERSION`.
- 5 and 6: 16'h0000.

**FIFO**
- Show-ahead FIFO: `req_valid = ~empty`, and the `req_*` outputs reflect the head entry.
- Pop on `req_valid & req_ready`.
- The full flag is registered. A push while full is dropped even if a pop happens in the same cycle, and the drop sets sticky `overflow`.
- `overflow` clears on a status-read-end event. If a drop and a clear occur in the same cycle, set wins.

**Outstanding counter** (width clog2(DEPTH+2))
- +1 on an accepted push; −1 on `rsp_valid`.
- A push and a response in the same cycle leave it unchanged.
- Saturates at 0, so a stray `rsp_valid` is ignored.
- `busy` is a registered copy of (counter != 0).
- The read-data register loads `rsp_data` on `rsp_valid & rsp_read`.

**Reset values**
- `ctrl` = 0, FIFO empty, `req_valid` = 0, `busy` = 0, `overflow` = 0.
- Read data, staging registers and counter = 0.
- Synchroniser flops reset to 1 (strobes idle high).
- Reset asserted mid-operation discards all queued entries. Any responses arriving afterwards hit the saturation rule.

## Timing
- Write event detect: 2 `sys_clk` after the `pi_wr` pin falls (3 worst case).
- Push registers on the detect edge.
- `req_valid` and `busy` are high in the cycle after the push edge, when the FIFO was empty and idle.
- `busy` falls the cycle after the `rsp_valid` that takes the counter to 0.
- A read result is visible on `pi_data_out` the cycle after `rsp_valid`.
- The Pi must hold `pi_a` and `pi_data_in` for at least 4 `sys_clk` after `pi_wr` falls.
- Throughput: one pop per cycle while `req_ready` is high; `req_*` outputs change only on pop or on a push into an empty FIFO.

## Test plan
- **Basic read:** write reg2 = 0x1234, then reg3 = 0x0412 (read, size 0, fc 0, addr[23:16] 0x12) -> `req_valid` with `req_address` 0x121234, `req_read` 1; `busy` 1. Then `rsp_valid` + `rsp_read` with 0xDEADBEEF -> reg0 reads 0xBEEF, reg1 reads 0xDEAD, `busy` 0.
- **Overflow:** with `req_ready` = 0 and DEPTH = 4, push 5 entries -> 4 held, status bits 10 and 9 set. A status read clears bit 10 only; the pops then return the 4 entries in order.
- **Control register:** write reg4 = 0x8005, then 0x0001 -> `ctrl` = 0x0004.
- **Simultaneous events:** a push in the same cycle as `rsp_valid` with counter = 1 -> counter stays 1 and `busy` stays 1. `rsp_valid` with counter = 0 -> counter stays 0.
- **Reset mid-operation:** assert `nRESET` with 3 entries queued -> `req_valid`, `busy` and `ctrl` are 0 immediately; reg7 still reads 0x1040.
- **Data output enable:** `pi_rd` = 0 and `pi_wr` = 1 -> `pi_data_oe` = 1; every other strobe combination -> 0.
